apb_master_arbiter: RTL and testbench

//   APB master sequencer that shares one APB slave port between NREQ requesters.
//   - Round-robin arbitration between requesters.
//   - Generates the IDLE -> SETUP -> ACCESS protocol sequence, including wait states.
//   - Returns read data and error status to the requester that won the grant.
//   - Sits between internal requesters (CPU bridge, DMA) and the AMBA_APB slave.

---
 rtl/apb_master_arbiter.sv | 191 +++++++++++++++++++
 tb/tb_apb_master_arbiter.sv | 295 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/apb_master_arbiter.sv
// Round-robin APB master: shares one APB slave port between NREQ requesters.
// Optional ACCESS-phase watchdog enabled by defining APB_TIMEOUT_EN.
module apb_master_arbiter #(
  parameter int NREQ    = 2,
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 16
) (
  input  logic                     pclk,
  input  logic                     prst,
  input  logic [NREQ-1:0]          req_valid,
  input  logic [NREQ-1:0]          req_write,
  input  logic [NREQ*ADDR_W-1:0]   req_addr,
  input  logic [NREQ*DATA_W-1:0]   req_wdata,
  output logic [NREQ-1:0]          req_done,
  output logic [DATA_W-1:0]        rsp_rdata,
  output logic                     rsp_err,
  output logic                     busy,
  output logic [ADDR_W-1:0]        paddr,
  output logic                     pselx,
  output logic                     penable,
  output logic                     pwrite,
  output logic [DATA_W-1:0]        pwdata,
  input  logic                     pready,
  input  logic                     pslverr,
  input  logic [DATA_W-1:0]        prdata
);
  localparam int IDX_W = (NREQ > 1) ? $clog2(NREQ) : 1;

  typedef enum logic [1:0] {S_IDLE, S_SETUP, S_ACCESS} state_t;

  state_t              state_q, state_d;
  logic [IDX_W-1:0]    ptr_q, ptr_d;
  logic [NREQ-1:0]     done_q, done_d;
  logic [DATA_W-1:0]   rdata_q, rdata_d;
  logic                err_q, err_d;
  logic                busy_q, busy_d;
  logic [ADDR_W-1:0]   paddr_q, paddr_d;
  logic                psel_q, psel_d;
  logic                penable_q, penable_d;
  logic                pwrite_q, pwrite_d;
  logic [DATA_W-1:0]   pwdata_q, pwdata_d;

  logic [ADDR_W-1:0]   addr_arr  [NREQ];
  logic [DATA_W-1:0]   wdata_arr [NREQ];
  logic [NREQ-1:0]     eligible;
  logic                gnt_found;
  logic [IDX_W-1:0]    gnt_idx;
  logic                timeout_hit;

  genvar gi;
  generate
    for (gi = 0; gi < NREQ; gi++) begin : g_unpack
      assign addr_arr[gi]  = req_addr[gi*ADDR_W +: ADDR_W];
      assign wdata_arr[gi] = req_wdata[gi*DATA_W +: DATA_W];
    end
  endgenerate

  // A requester whose completion pulse is on the wire cannot be re-granted yet.
  assign eligible = req_valid & ~done_q;

  // First eligible index above the pointer, otherwise the first from zero (wrap).
  always_comb begin
    gnt_found = 1'b0;
    gnt_idx   = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (!gnt_found && eligible[i] && (IDX_W'(i) > ptr_q)) begin
        gnt_found = 1'b1;
        gnt_idx   = IDX_W'(i);
      end
    end
    for (int i = 0; i < NREQ; i++) begin
      if (!gnt_found && eligible[i]) begin
        gnt_found = 1'b1;
        gnt_idx   = IDX_W'(i);
      end
    end
  end

`ifdef APB_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT + 1);
  logic [CNT_W-1:0] cnt_q, cnt_d;

  assign cnt_d       = (state_q == S_ACCESS) ? cnt_q + CNT_W'(1) : '0;
  assign timeout_hit = (state_q == S_ACCESS) && !pready && (cnt_q == CNT_W'(TIMEOUT - 1));

  always_ff @(posedge pclk or posedge prst) begin
    if (prst) cnt_q <= '0;
    else      cnt_q <= cnt_d;
  end
`else
  assign timeout_hit = 1'b0;
`endif

  always_ff @(posedge pclk or posedge prst) begin
    if (prst) state_q <= S_IDLE;
    else      state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:   if (gnt_found) state_d = S_SETUP;
      S_SETUP:  state_d = S_ACCESS;
      S_ACCESS: if (pready || timeout_hit) state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  always_comb begin
    ptr_d     = ptr_q;
    done_d    = '0;
    rdata_d   = rdata_q;
    err_d     = err_q;
    paddr_d   = paddr_q;
    psel_d    = psel_q;
    penable_d = penable_q;
    pwrite_d  = pwrite_q;
    pwdata_d  = pwdata_q;
    unique case (state_q)
      S_IDLE: begin
        if (gnt_found) begin
          ptr_d    = gnt_idx;
          paddr_d  = addr_arr[gnt_idx];
          pwrite_d = req_write[gnt_idx];
          pwdata_d = wdata_arr[gnt_idx];
          psel_d   = 1'b1;
        end
      end
      S_SETUP: penable_d = 1'b1;
      S_ACCESS: begin
        if (pready) begin
          psel_d         = 1'b0;
          penable_d      = 1'b0;
          done_d[ptr_q]  = 1'b1;
          err_d          = pslverr;
          if (!pwrite_q) rdata_d = prdata;
        end else if (timeout_hit) begin
          psel_d         = 1'b0;
          penable_d      = 1'b0;
          done_d[ptr_q]  = 1'b1;
          err_d          = 1'b1;
          rdata_d        = '0;
        end
      end
      default: begin
        psel_d    = 1'b0;
        penable_d = 1'b0;
      end
    endcase
    busy_d = (state_d != S_IDLE);
  end

  // Pointer resets to the last index so requester 0 wins the first arbitration.
  always_ff @(posedge pclk or posedge prst) begin
    if (prst) begin
      ptr_q     <= IDX_W'(NREQ - 1);
      done_q    <= '0;
      rdata_q   <= '0;
      err_q     <= 1'b0;
      busy_q    <= 1'b0;
      paddr_q   <= '0;
      psel_q    <= 1'b0;
      penable_q <= 1'b0;
      pwrite_q  <= 1'b0;
      pwdata_q  <= '0;
    end else begin
      ptr_q     <= ptr_d;
      done_q    <= done_d;
      rdata_q   <= rdata_d;
      err_q     <= err_d;
      busy_q    <= busy_d;
      paddr_q   <= paddr_d;
      psel_q    <= psel_d;
      penable_q <= penable_d;
      pwrite_q  <= pwrite_d;
      pwdata_q  <= pwdata_d;
    end
  end

  assign req_done  = done_q;
  assign rsp_rdata = rdata_q;
  assign rsp_err   = err_q;
  assign busy      = busy_q;
  assign paddr     = paddr_q;
  assign pselx     = psel_q;
  assign penable   = penable_q;
  assign pwrite    = pwrite_q;
  assign pwdata    = pwdata_q;

endmodule

// File: tb/tb_apb_master_arbiter.sv
// Randomized scoreboard bench for apb_master_arbiter: timestamped reference
// arbiter predicts each bus transfer and completion; a monitor checks them.
module tb_apb_master_arbiter;
  localparam int NREQ = 3;
  localparam int AW   = 32;
  localparam int DW   = 32;

  logic                 pclk = 1'b0;
  logic                 prst = 1'b1;
  logic [NREQ-1:0]      req_valid = '0;
  logic [NREQ-1:0]      req_write = '0;
  logic [NREQ*AW-1:0]   req_addr  = '0;
  logic [NREQ*DW-1:0]   req_wdata = '0;
  logic [NREQ-1:0]      req_done;
  logic [DW-1:0]        rsp_rdata;
  logic                 rsp_err;
  logic                 busy;
  logic [AW-1:0]        paddr;
  logic                 pselx;
  logic                 penable;
  logic                 pwrite;
  logic [DW-1:0]        pwdata;
  logic                 pready  = 1'b0;
  logic                 pslverr = 1'b0;
  logic [DW-1:0]        prdata  = '0;

  always #5 pclk = ~pclk;

  apb_master_arbiter #(.NREQ(NREQ), .ADDR_W(AW), .DATA_W(DW), .TIMEOUT(16)) dut (
    .pclk(pclk), .prst(prst),
    .req_valid(req_valid), .req_write(req_write), .req_addr(req_addr), .req_wdata(req_wdata),
    .req_done(req_done), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err), .busy(busy),
    .paddr(paddr), .pselx(pselx), .penable(penable), .pwrite(pwrite), .pwdata(pwdata),
    .pready(pready), .pslverr(pslverr), .prdata(prdata)
  );

  typedef struct {
    int          g;
    logic [31:0] addr;
    logic        wr;
    logic [31:0] wdata;
    int          t;
    int          w;
    logic [31:0] rdata;
    logic        err;
  } xfer_t;

  xfer_t exp_q[$];
  xfer_t slave_q[$];

  int checks = 0;
  int errors = 0;
  int edge_cnt = 0;
  bit mon_en = 0;
  bit slave_en = 0;

  // Reference arbiter state: transfers are timestamped by the edge they are granted on.
  int ptr;
  int free_edge;
  int done_g;
  int done_edge;
  bit [NREQ-1:0] in_flight = '0;
  bit [NREQ-1:0] fin = '0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req_v);
    checks++;
    if (act !== req_v) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h (edge %0d)", name, act, req_v, edge_cnt);
    end
  endtask

  task automatic model_step();
    logic [NREQ-1:0] elig;
    int g;
    xfer_t rec;
    if (edge_cnt < free_edge) return;
    elig = req_valid;
    if (edge_cnt == done_edge + 1 && done_g >= 0) elig[done_g] = 1'b0;
    g = -1;
    for (int k = 1; k <= NREQ; k++) begin
      int idx;
      idx = (ptr + k) % NREQ;
      if (g < 0 && elig[idx]) g = idx;
    end
    if (g < 0) return;
    rec.g     = g;
    rec.addr  = req_addr[g*AW +: AW];
    rec.wr    = req_write[g];
    rec.wdata = req_wdata[g*DW +: DW];
    rec.t     = edge_cnt;
    rec.w     = ($urandom_range(0, 4) == 0) ? int'($urandom_range(3, 6)) : int'($urandom_range(0, 2));
    rec.rdata = $urandom;
    rec.err   = ($urandom_range(0, 3) == 0);
    exp_q.push_back(rec);
    slave_q.push_back(rec);
    ptr          = g;
    in_flight[g] = 1'b1;
    done_g       = g;
    done_edge    = edge_cnt + 2 + rec.w;
    free_edge    = edge_cnt + 3 + rec.w;
  endtask

  task automatic new_req(input int i);
    req_valid[i]          = 1'b1;
    req_write[i]          = $urandom_range(0, 1);
    req_addr[i*AW +: AW]  = $urandom;
    req_wdata[i*DW +: DW] = $urandom;
  endtask

  task automatic drive_reqs(input bit allow);
    for (int i = 0; i < NREQ; i++) begin
      if (fin[i]) begin
        fin[i] = 1'b0;
        if (allow && $urandom_range(0, 1) == 1) new_req(i);
        else req_valid[i] = 1'b0;
      end else if (req_done[i]) begin
        // Keep valid up through the done cycle: it must not be re-granted.
        fin[i]       = 1'b1;
        in_flight[i] = 1'b0;
      end else if (in_flight[i]) begin
        if ($urandom_range(0, 3) == 0) begin
          req_write[i]          = ~req_write[i];
          req_addr[i*AW +: AW]  = $urandom;
          req_wdata[i*DW +: DW] = $urandom;
        end
      end else if (req_valid[i]) begin
        if ($urandom_range(0, 15) == 0) req_valid[i] = 1'b0;
      end else if (allow && $urandom_range(0, 2) == 0) begin
        new_req(i);
      end
    end
  endtask

  // APB slave: wait-state count and response come from the reference model.
  int          wl = 0;
  logic [31:0] s_rdata = '0;
  logic        s_err = 1'b0;
  always @(negedge pclk) begin
    if (slave_en) begin
      if (pselx && !penable) begin
        if (slave_q.size() > 0) begin
          xfer_t s;
          s       = slave_q.pop_front();
          wl      = s.w;
          s_rdata = s.rdata;
          s_err   = s.err;
        end
        pready  = $urandom_range(0, 1);
        prdata  = $urandom;
        pslverr = $urandom_range(0, 1);
      end else if (pselx && penable) begin
        if (wl == 0) begin
          pready  = 1'b1;
          prdata  = s_rdata;
          pslverr = s_err;
        end else begin
          pready  = 1'b0;
          prdata  = $urandom;
          pslverr = $urandom_range(0, 1);
          wl--;
        end
      end else begin
        pready  = $urandom_range(0, 1);
        prdata  = $urandom;
        pslverr = $urandom_range(0, 1);
      end
    end
  end

  // Monitor: pops the expected transfer at SETUP, checks its completion.
  xfer_t       cur;
  bit          active = 0;
  int          acc_cnt = 0;
  logic [31:0] last_rdata = '0;
  logic        last_err = 1'b0;
  always @(negedge pclk) begin
    if (mon_en) begin
      if (pselx && !penable) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL setup_unexpected actual=bus_start required=no_transfer (edge %0d)", edge_cnt);
        end else begin
          cur     = exp_q.pop_front();
          active  = 1;
          acc_cnt = 0;
          chk("grant_edge", 64'(edge_cnt), 64'(cur.t));
          chk("paddr", 64'(paddr), 64'(cur.addr));
          chk("pwrite", 64'(pwrite), 64'(cur.wr));
          if (cur.wr) chk("pwdata", 64'(pwdata), 64'(cur.wdata));
          chk("busy_setup", 64'(busy), 64'(1));
          chk("rsp_hold", 64'({rsp_err, rsp_rdata}), 64'({last_err, last_rdata}));
        end
      end else if (pselx && penable && active) begin
        acc_cnt++;
        if (paddr !== cur.addr) chk("paddr_access", 64'(paddr), 64'(cur.addr));
      end
      if (req_done != '0) begin
        if (!active) begin
          checks++;
          errors++;
          $display("FAIL done_unexpected actual=%0h required=0 (edge %0d)", req_done, edge_cnt);
        end else begin
          logic [NREQ-1:0] ed;
          ed = '0;
          ed[cur.g] = 1'b1;
          chk("req_done", 64'(req_done), 64'(ed));
          chk("done_edge", 64'(edge_cnt), 64'(cur.t + 2 + cur.w));
          chk("rsp_err", 64'(rsp_err), 64'(cur.err));
          chk("rsp_rdata", 64'(rsp_rdata), 64'(cur.wr ? last_rdata : cur.rdata));
          chk("access_cycles", 64'(acc_cnt), 64'(cur.w + 1));
          chk("bus_idle_after", 64'({pselx, penable, busy}), 64'(0));
          if (!cur.wr) last_rdata = cur.rdata;
          last_err = cur.err;
          active   = 0;
          $display("xfer req=%0d %s addr=%h wdata=%h waits=%0d rdata=%h err=%0d",
                   cur.g, cur.wr ? "WR" : "RD", cur.addr, cur.wdata, cur.w, rsp_rdata, rsp_err);
        end
      end else if (active && edge_cnt > cur.t + cur.w + 6) begin
        checks++;
        errors++;
        $display("FAIL done_timeout actual=no_done required=done_by_edge_%0d", cur.t + 2 + cur.w);
        active = 0;
      end
    end
  end

  initial begin
    int n;
    ptr       = NREQ - 1;
    free_edge = 0;
    done_g    = -1;
    done_edge = -10;

    repeat (2) @(posedge pclk);
    @(negedge pclk);
    chk("reset_ctrl", 64'({req_done, rsp_err, busy, pselx, penable, pwrite}), 64'(0));
    chk("reset_rdata", 64'(rsp_rdata), 64'(0));
    chk("reset_paddr", 64'(paddr), 64'(0));
    chk("reset_pwdata", 64'(pwdata), 64'(0));
    prst     = 1'b0;
    mon_en   = 1;
    slave_en = 1;

    for (int cyc = 0; cyc < 2400; cyc++) begin
      @(posedge pclk);
      edge_cnt++;
      model_step();
      @(negedge pclk);
      drive_reqs(cyc < 2200);
    end
    chk("drain_expected", 64'(exp_q.size()), 64'(0));
    chk("drain_active", 64'(active), 64'(0));

    // Asynchronous reset in the middle of ACCESS, then requester 0 must win.
    mon_en   = 0;
    slave_en = 0;
    pready   = 1'b0;
    pslverr  = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      req_valid[i]         = 1'b1;
      req_write[i]         = 1'b0;
      req_addr[i*AW +: AW] = 32'h100 + 32'(i * 4);
    end
    n = 0;
    while (!(pselx && penable) && n < 20) begin
      @(negedge pclk);
      n++;
    end
    chk("reach_access", 64'(pselx && penable), 64'(1));
    #2 prst = 1'b1;
    #1;
    chk("rst_async_bus", 64'({pselx, penable, busy, req_done}), 64'(0));
    chk("rst_async_rsp", 64'({rsp_err, rsp_rdata}), 64'(0));
    @(negedge pclk);
    prst   = 1'b0;
    pready = 1'b1;
    @(negedge pclk);
    chk("post_rst_grant", 64'({pselx, penable, paddr}), 64'({1'b1, 1'b0, 32'h100}));
    n = 0;
    while (req_done == '0 && n < 10) begin
      @(negedge pclk);
      n++;
    end
    chk("post_rst_done", 64'(req_done), 64'(1));
    $display("xfer post-reset req_done=%b paddr=%h", req_done, paddr);
    req_valid = '0;
    @(negedge pclk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
